rr_issue_scheduler: RTL
=======================

# rr_issue_scheduler

Sequential issue scheduler that shares one multi-cycle functional unit among the 16 reservation-station entries of the out-of-order core. Each cycle it selects one ready entry with a rotating round-robin priority, holds a registered one-hot grant until the functional unit accepts it, and then blocks further grants until the unit's occupancy expires. It replaces fixed-priority selection on the issue path, where low-numbered entries starve high-numbered ones.

## Interface
- N, 16, number of requesting entries (fixed at 16; grant_idx encoding depends on it)
- LAT_W, 3, width of per-entry occupancy field
- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- req  in  16  entry i ready to issue
- op_lat  in  16*LAT_W  occupancy of entry i's op in cycles, bits [i*LAT_W +: LAT_W]
- fu_accept  in  1  functional unit takes the presented grant this cycle
- flush  in  1  pipeline flush: drop pending grant and busy state
- grant  out  16  registered one-hot grant, all-zero when none
- grant_valid  out  1  OR of grant
- grant_idx  out  5  index of set grant bit, 16 when none
- fu_busy  out  1  unit occupied by a multi-cycle op

## Operation
- States: IDLE, GRANT, BUSY. Reset: IDLE, grant=0, grant_valid=0, grant_idx=16, fu_busy=0, rr pointer=0, busy counter=0.
- Selection: first set bit of req scanning ptr, ptr+1, ..., ptr+15 (mod 16).
- IDLE: if any req, register selected grant, go GRANT; else stay.
- GRANT: grant held stable while req[granted] stays 1 and fu_accept=0.
  - req[granted] drops without accept: grant cleared, back to IDLE (pointer unchanged).
  - fu_accept: ptr <= granted+1 (15 wraps to 0); latch L = op_lat[granted].
    - L<=1: select again from req with granted bit masked; if any, new grant next cycle, stay GRANT (back-to-back issue); else IDLE.
    - L>=2: grant cleared, counter <= L-1, fu_busy=1, go BUSY.
- BUSY: counter decrements each cycle; at counter==1 going to 0, fu_busy drops and state returns to IDLE (selection resumes in IDLE next cycle).
- flush (any state): grant cleared, fu_busy=0, counter=0, state IDLE; ptr unchanged. flush wins over simultaneous fu_accept (no pointer update, no latch).
- RESET overrides flush and everything else.
- grant_idx and grant_valid are derived from the grant register only; never X, never multi-hot.

## Timing
- req asserted in IDLE at cycle t -> grant visible at t+1.
- fu_accept at t with L<=1 -> next grant (if any other req) at t+1.
- fu_accept at t with L -> fu_busy high t+1..t+L-1, state IDLE at t+L, next grant at t+L+1.
- L=0 treated as 1.
- RESET sampled high at t -> all outputs at reset values from t+1.

## Configuration
- SCHED_AGING_EN defined: per-entry 4-bit age counter, increments each cycle req[i]=1 and entry not granted, clears on accept of i, req[i]=0, flush, or reset; saturates at 15. Any entry with age>=8 takes priority over round-robin (lowest index among aged entries); ptr still advances on accept.
- Not defined: pure round-robin, no age state.

## Test plan
- Reset then req=0x0001 -> grant=0x0001, grant_idx=0 one cycle later; fu_accept with op_lat[0]=1 -> ptr=1, grant=0 next cycle, grant_idx=16.
- req=0xFFFF held, fu_accept every cycle, all lat=1 -> grants 0,1,2,...,15,0 in consecutive cycles, no gaps.
- req=0x8001, ptr=15 -> grant_idx=15; accept -> ptr=0 (wrap), next grant_idx=0.
- op_lat[3]=5, req=0x0008, accept at t -> fu_busy=1 t+1..t+4, no grant until t+6 even with req=0xFFFF.
- Grant pending on entry 4, flush and fu_accept same cycle -> grant=0, fu_busy=0, ptr unchanged next cycle; req[4] drop without accept -> grant cleared, state IDLE.
- SCHED_AGING_EN, entry 9 requesting while entries 0-2 re-request and are granted repeatedly with ptr kept below 9 -> entry 9 granted no later than 9 cycles after its first req.

Source files
------------

// File: rtl/rr_issue_scheduler.sv
// Round-robin issue scheduler sharing one multi-cycle functional unit among 16 entries.
// Optional SCHED_AGING_EN: per-entry age counters let long-waiting entries pre-empt round-robin.
module rr_issue_scheduler #(
  parameter int N     = 16,
  parameter int LAT_W = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N-1:0]       req_i,
  input  logic [N*LAT_W-1:0] op_lat_i,
  input  logic               fu_accept_i,
  input  logic               flush_i,
  output logic [N-1:0]       grant_o,
  output logic               grant_valid_o,
  output logic [4:0]         grant_idx_o,
  output logic               fu_busy_o
);

  localparam int PW = $clog2(N);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    g_idx;
  logic [PW-1:0]    ptr_nxt;
  logic [LAT_W-1:0] lat_g;
  logic [N-1:0]     req_mask;
  logic [N-1:0]     pick_idle, pick_b2b;
  logic [N-1:0]     aged;
  logic             accepted;

  // Rotating scan: descending loop so the smallest offset from p wins.
  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] r, input logic [PW-1:0] p);
    logic [N-1:0]  g;
    logic [PW-1:0] idx;
    g = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = p + PW'(k);
      if (r[idx]) g = N'(1) << idx;
    end
    return g;
  endfunction

  function automatic logic [N-1:0] sel(input logic [N-1:0] r, input logic [PW-1:0] p,
                                       input logic [N-1:0] a);
    logic [N-1:0] ra;
    ra = r & a;
    if (|ra) return ra & (~ra + N'(1));
    return rr_pick(r, p);
  endfunction

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < N; i++)
      if (grant_q[i]) g_idx = PW'(i);
  end

  assign ptr_nxt   = g_idx + PW'(1);
  assign lat_g     = op_lat_i[g_idx*LAT_W +: LAT_W];
  assign req_mask  = req_i & ~grant_q;
  assign pick_idle = sel(req_i, ptr_q, aged);
  assign pick_b2b  = sel(req_mask, ptr_nxt, aged);
  assign accepted  = (state_q == S_GRANT) && fu_accept_i && !flush_i;

`ifdef SCHED_AGING_EN
  logic [N-1:0][3:0] age_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      age_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!req_i[i] || (accepted && grant_q[i])) age_q[i] <= 4'd0;
        else if (!grant_q[i] && age_q[i] != 4'd15) age_q[i] <= age_q[i] + 4'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) aged[i] = age_q[i][3];
  end
`else
  assign aged = '0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          grant_d = pick_idle;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (fu_accept_i) begin
          ptr_d = ptr_nxt;
          // Zero latency behaves as single-cycle: back-to-back issue.
          if (lat_g <= LAT_W'(1)) begin
            grant_d = pick_b2b;
            state_d = (|req_mask) ? S_GRANT : S_IDLE;
          end else begin
            grant_d = '0;
            cnt_d   = lat_g - LAT_W'(1);
            state_d = S_BUSY;
          end
        end else if (!(|(req_i & grant_q))) begin
          grant_d = '0;
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - LAT_W'(1);
        if (cnt_q <= LAT_W'(1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    if (flush_i) begin
      grant_d = '0;
      cnt_d   = '0;
      ptr_d   = ptr_q;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_valid_o = |grant_q;
  assign grant_idx_o   = grant_valid_o ? {1'b0, g_idx} : 5'd16;
  assign fu_busy_o     = (state_q == S_BUSY);

endmodule
